// File: rtl/xaddrgen3_if.sv
// Configuration, run handshake and address-stream bundle for xaddrgen3.
//   master: controller side, drives run and the loop configuration, observes the stream.
//   slave : generator side, samples run/config, drives addr, mem_en and done.
// Signals:
//   run                                  start pulse
//   iterations/iterations2/iterations3   loop counts for levels 1..3 (0 acts as 1)
//   period, duty, delay                  period length, enabled cycles per period, start delay
//   start, incr, shift, shift2, shift3   base address, per-cycle step, per-level base steps
//   addr, mem_en, done                   registered address, memory enable, idle flag
interface xaddrgen3_if #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned PERIOD_W = 10
);
  logic                run;
  logic [ADDR_W-1:0]   iterations;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] duty;
  logic [ADDR_W-1:0]   start;
  logic [ADDR_W-1:0]   incr;
  logic [ADDR_W-1:0]   shift;
  logic [PERIOD_W-1:0] delay;
  logic [ADDR_W-1:0]   iterations2;
  logic [ADDR_W-1:0]   shift2;
  logic [ADDR_W-1:0]   iterations3;
  logic [ADDR_W-1:0]   shift3;
  logic [ADDR_W-1:0]   addr;
  logic                mem_en;
  logic                done;

  modport master (
    output run, iterations, period, duty, start, incr, shift, delay,
           iterations2, shift2, iterations3, shift3,
    input  addr, mem_en, done
  );

  modport slave (
    input  run, iterations, period, duty, start, incr, shift, delay,
           iterations2, shift2, iterations3, shift3,
    output addr, mem_en, done
  );
endinterface

// File: rtl/xaddrgen3.sv
// Three-level nested-loop address generator for one Versat data-memory port.
// After run (sampled in idle) it waits delay cycles, then emits one address per cycle:
//   addr = start + m*shift3 + k*shift2 + i*shift + j*incr  (mod 2^ADDR_W)
//   mem_en = (j < duty)
// with j innermost over period, then i, k, m over the three iteration counts.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  xaddrgen3_if slave modport (run/config in, addr/mem_en/done out)
module xaddrgen3 #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned PERIOD_W = 10
) (
  input logic       clk,
  input logic       rst,
  xaddrgen3_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StDelay, StActive} state_e;

  state_e              state;
  logic [PERIOD_W-1:0] j_cnt;
  logic [PERIOD_W-1:0] dly_cnt;
  logic [ADDR_W-1:0]   i_cnt;
  logic [ADDR_W-1:0]   k_cnt;
  logic [ADDR_W-1:0]   m_cnt;
  logic [ADDR_W-1:0]   base1;
  logic [ADDR_W-1:0]   base2;
  logic [ADDR_W-1:0]   base3;
  logic [ADDR_W-1:0]   cur_addr;
  logic                cur_en;
  logic                cur_done;

  // Last index of each loop; a zero count behaves as a count of one.
  logic [PERIOD_W-1:0] j_last;
  logic [ADDR_W-1:0]   i_last;
  logic [ADDR_W-1:0]   k_last;
  logic [ADDR_W-1:0]   m_last;

  always_comb begin
    j_last = (bus.period == '0)      ? '0 : bus.period - 1'b1;
    i_last = (bus.iterations == '0)  ? '0 : bus.iterations - 1'b1;
    k_last = (bus.iterations2 == '0) ? '0 : bus.iterations2 - 1'b1;
    m_last = (bus.iterations3 == '0) ? '0 : bus.iterations3 - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      j_cnt    <= '0;
      dly_cnt  <= '0;
      i_cnt    <= '0;
      k_cnt    <= '0;
      m_cnt    <= '0;
      base1    <= '0;
      base2    <= '0;
      base3    <= '0;
      cur_addr <= '0;
      cur_en   <= 1'b0;
      cur_done <= 1'b1;
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.run) begin
            cur_done <= 1'b0;
            j_cnt    <= '0;
            i_cnt    <= '0;
            k_cnt    <= '0;
            m_cnt    <= '0;
            base1    <= bus.start;
            base2    <= bus.start;
            base3    <= bus.start;
            if (bus.delay == '0) begin
              state    <= StActive;
              cur_addr <= bus.start;
              cur_en   <= (bus.duty != '0);
            end else begin
              // Edge E0 counts as the first delay cycle.
              state   <= StDelay;
              dly_cnt <= {{(PERIOD_W-1){1'b0}}, 1'b1};
              cur_en  <= 1'b0;
            end
          end
        end
        StDelay: begin
          if (dly_cnt == bus.delay) begin
            state    <= StActive;
            cur_addr <= bus.start;
            cur_en   <= (bus.duty != '0);
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        StActive: begin
          if (j_cnt != j_last) begin
            j_cnt    <= j_cnt + 1'b1;
            cur_addr <= cur_addr + bus.incr;
            cur_en   <= ((j_cnt + 1'b1) < bus.duty);
          end else begin
            j_cnt  <= '0;
            cur_en <= (bus.duty != '0);
            if (i_cnt != i_last) begin
              i_cnt    <= i_cnt + 1'b1;
              base1    <= base1 + bus.shift;
              cur_addr <= base1 + bus.shift;
            end else begin
              i_cnt <= '0;
              if (k_cnt != k_last) begin
                k_cnt    <= k_cnt + 1'b1;
                base2    <= base2 + bus.shift2;
                base1    <= base2 + bus.shift2;
                cur_addr <= base2 + bus.shift2;
              end else begin
                k_cnt <= '0;
                if (m_cnt != m_last) begin
                  m_cnt    <= m_cnt + 1'b1;
                  base3    <= base3 + bus.shift3;
                  base2    <= base3 + bus.shift3;
                  base1    <= base3 + bus.shift3;
                  cur_addr <= base3 + bus.shift3;
                end else begin
                  // Final cycle: addr holds its last value.
                  m_cnt    <= '0;
                  state    <= StIdle;
                  cur_en   <= 1'b0;
                  cur_done <= 1'b1;
                end
              end
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.addr   = cur_addr;
  assign bus.mem_en = cur_en;
  assign bus.done   = cur_done;

endmodule

// File: tb/tb_xaddrgen3.sv
// Self-checking bench for xaddrgen3: directed cases plus randomized configurations,
// compared against a nested-loop reference model built with plain arithmetic.
module tb_xaddrgen3;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  xaddrgen3_if #(.ADDR_W(10), .PERIOD_W(10)) bus ();

  xaddrgen3 #(.ADDR_W(10), .PERIOD_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned exp_addr[$];
  bit          exp_en[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_cfg(input int unsigned st, input int unsigned inc, input int unsigned per,
                         input int unsigned dut_y, input int unsigned it1, input int unsigned sh1,
                         input int unsigned it2, input int unsigned sh2, input int unsigned it3,
                         input int unsigned sh3, input int unsigned dly);
    bus.start       = 10'(st);
    bus.incr        = 10'(inc);
    bus.period      = 10'(per);
    bus.duty        = 10'(dut_y);
    bus.iterations  = 10'(it1);
    bus.shift       = 10'(sh1);
    bus.iterations2 = 10'(it2);
    bus.shift2      = 10'(sh2);
    bus.iterations3 = 10'(it3);
    bus.shift3      = 10'(sh3);
    bus.delay       = 10'(dly);
  endtask

  // Reference: enumerate the loop nest directly from the current configuration.
  task automatic build_model();
    int unsigned p, n1, n2, n3, a;
    exp_addr.delete();
    exp_en.delete();
    p  = (bus.period == 0)      ? 1 : int'(bus.period);
    n1 = (bus.iterations == 0)  ? 1 : int'(bus.iterations);
    n2 = (bus.iterations2 == 0) ? 1 : int'(bus.iterations2);
    n3 = (bus.iterations3 == 0) ? 1 : int'(bus.iterations3);
    for (int unsigned m = 0; m < n3; m++)
      for (int unsigned k = 0; k < n2; k++)
        for (int unsigned i = 0; i < n1; i++)
          for (int unsigned j = 0; j < p; j++) begin
            a = int'(bus.start) + m * int'(bus.shift3) + k * int'(bus.shift2)
              + i * int'(bus.shift) + j * int'(bus.incr);
            exp_addr.push_back(a % 1024);
            exp_en.push_back(j < int'(bus.duty));
          end
  endtask

  // Pulse run and follow the whole run. extra_run re-pulses run during the delay phase.
  // abort_at >= 0 asserts reset during that active cycle and checks the reset values.
  task automatic do_run(input string name, input bit extra_run, input int abort_at);
    int unsigned d;
    int unsigned last;
    build_model();
    d = bus.delay;
    @(negedge clk);
    bus.run = 1'b1;
    @(posedge clk);
    #1;
    bus.run = 1'b0;
    check({name, " done@E0"}, bus.done, 0);
    for (int unsigned n = 0; n < d; n++) begin
      check({name, " dly_en"}, bus.mem_en, 0);
      check({name, " dly_done"}, bus.done, 0);
      if (extra_run && n == 0) bus.run = 1'b1;
      @(posedge clk);
      #1;
      bus.run = 1'b0;
    end
    for (int n = 0; n < exp_addr.size(); n++) begin
      check({name, " addr"}, bus.addr, exp_addr[n]);
      check({name, " en"}, bus.mem_en, exp_en[n]);
      check({name, " busy"}, bus.done, 0);
      if (n == abort_at) begin
        #2;
        rst = 1'b1;
        #1;
        check({name, " rst_addr"}, bus.addr, 0);
        check({name, " rst_en"}, bus.mem_en, 0);
        check({name, " rst_done"}, bus.done, 1);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    last = exp_addr[exp_addr.size() - 1];
    check({name, " end_done"}, bus.done, 1);
    check({name, " end_en"}, bus.mem_en, 0);
    check({name, " end_addr"}, bus.addr, last);
    if (extra_run) begin
      // The ignored re-run must not have launched a second pass.
      @(posedge clk);
      #1;
      check({name, " stay_idle"}, bus.done, 1);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    bus.run = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("reset addr", bus.addr, 0);
    check("reset en", bus.mem_en, 0);
    check("reset done", bus.done, 1);
    @(negedge clk);
    rst = 1'b0;

    set_cfg(4, 1, 4, 4, 1, 0, 1, 0, 1, 0, 0);
    do_run("linear", 1'b0, -1);
    set_cfg(0, 2, 3, 2, 2, 10, 1, 0, 1, 0, 0);
    do_run("duty_shift", 1'b0, -1);
    set_cfg(1020, 2, 2, 2, 1, 0, 2, 100, 2, 1000, 0);
    do_run("three_lvl", 1'b0, -1);
    set_cfg(7, 1, 0, 4, 0, 0, 1, 0, 1, 0, 3);
    do_run("delay_zero", 1'b1, -1);
    set_cfg(4, 1, 4, 4, 1, 0, 1, 0, 1, 0, 0);
    do_run("mid_reset", 1'b0, 2);
    do_run("after_reset", 1'b0, -1);
    set_cfg(100, 3, 3, 0, 2, 5, 1, 0, 1, 0, 1);
    do_run("duty0", 1'b0, -1);

    for (int c = 0; c < 30; c++) begin
      set_cfg($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 4),
              $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 1023),
              $urandom_range(0, 3), $urandom_range(0, 1023), $urandom_range(0, 3),
              $urandom_range(0, 1023), $urandom_range(0, 3));
      do_run("random", ($urandom_range(0, 1) == 1), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
